// File: rtl/sweep_pkg.sv
// Shared encodings and constants for the exhaustive truth-table checkers.
// Also holds the golden table reused by other lab checkers.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  localparam logic [15:0] TT_ABBAR_CDBAR = 16'h4F44;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Per-vector settle down-counter: load restarts it at SETTLE,
// expire flags the compare cycle.
module sweep_settle_timer #(
  parameter int SETTLE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [7:0] cnt;

  assign expire = (cnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= 8'(SETTLE);
    end else if (en && !expire) begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// Sweeps all 2^N_IN input vectors into a combinational DUT and
// checks each settled output against a golden truth table.
module exhaustive_sweep_checker
  import sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 0,
  parameter logic [tt_width(N_IN)-1:0] TRUTH_TABLE = TT_ABBAR_CDBAR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  sweep_state_t state_q, state_d;

  logic go;
  logic expire;
  logic cmp;
  logic last;
  logic mism;

  assign go   = (state_q != RUN) && start && !abort;
  assign cmp  = (state_q == RUN) && !abort && expire;
  assign last = (dut_in == '1);
  // X/Z on the DUT output must count as a failure
  assign mism = (dut_out !== TRUTH_TABLE[dut_in]);

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

  sweep_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (go || cmp),
    .en    (busy && !abort),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expire && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in           <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (go) begin
      dut_in           <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
    end else if (cmp) begin
      if (mism) begin
        err_count <= err_count + (N_IN + 1)'(1);
        if (!first_fail_valid) begin
          first_fail_vec   <= dut_in;
          first_fail_valid <= 1'b1;
        end
      end
      if (!last) begin
        dut_in <= dut_in + N_IN'(1);
      end
    end
  end

endmodule

// File: doc/exhaustive_sweep_checker.md
Name: exhaustive_sweep_checker

Overview:
- Synthesizable, parametrised exhaustive truth-table checker for combinational lab circuits with N_IN inputs and one output.
- Drives all 2^N_IN input vectors in ascending order (bit N_IN-1 = first operand, e.g. a of {a,b,c,d}) and waits a programmable settle time per vector.
- Compares the DUT output against a golden table parameter, then reports error count, first failing vector and pass/fail.
- Sits beside the DUT in on-board FPGA tests; replaces hand-written stimulus lists.

Parameters:
- N_IN, 4: number of DUT inputs, 1..8.
- SETTLE, 0: extra cycles each vector is held before compare, 0..255.
- TRUTH_TABLE, 16'h4F44: golden output; bit i = expected y for input vector i. Width 2^N_IN. Default encodes y = a&~b | c&~d.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin sweep; sampled in IDLE or DONE only
- abort  in  1  stop sweep, return to IDLE
- dut_out  in  1  DUT output under test
- dut_in  out  N_IN  vector driven to DUT
- busy  out  1  high while sweeping
- done  out  1  sweep completed; level, sticky
- pass  out  1  done && err_count==0
- err_count  out  N_IN+1  number of mismatching vectors
- first_fail_vec  out  N_IN  lowest-index failing vector
- first_fail_valid  out  1  first_fail_vec is meaningful

Behaviour:
- Reset (async, immediate): state=IDLE. dut_in, err_count, first_fail_vec and settle counter = 0. busy, done, pass and first_fail_valid = 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE after the last compare.
  - RUN -> IDLE on abort.
  - DONE -> RUN on start.
  - DONE -> IDLE on abort.
- Entering RUN (edge where start is seen):
  - dut_in=0, settle_cnt=0, err_count=0, first_fail_valid=0, done=0.
  - busy=1 from the next cycle.
- RUN, every cycle:
  - If settle_cnt<SETTLE: settle_cnt++.
  - Otherwise it is a compare cycle: the check passes only if dut_out === TRUTH_TABLE[dut_in]. X/Z on dut_out counts as a mismatch.
  - On mismatch: err_count++. If first_fail_valid==0, latch first_fail_vec=dut_in and set first_fail_valid=1.
  - Then, if dut_in==2^N_IN-1: go to DONE, busy=0, done=1. Otherwise dut_in++ and settle_cnt=0.
- Timing:
  - Each vector is held exactly SETTLE+1 cycles.
  - Full sweep = 2^N_IN*(SETTLE+1) cycles from the first RUN cycle to the cycle before done rises.
  - SETTLE=0 compares in the same cycle the vector is driven, so the DUT must be purely combinational.
- DONE: dut_in holds its last vector; all results hold until start or abort.
- Simultaneous start and abort: abort wins.
- start while in RUN: ignored, no restart.
- abort mid-RUN:
  - Go to IDLE; busy=0, done=0.
  - err_count and first_fail_* keep their partial values.
  - dut_in keeps its value until the next start.
- Mismatch on the final vector: counted before done rises; pass reflects it on the same edge.
- Width: err_count maxes at 2^N_IN, so it cannot overflow in N_IN+1 bits.
- pass is registered with done, never high while busy.
- rst asserted mid-sweep: all outputs return to reset values immediately, with no wait for a clock edge.

Decomposition:
- Shared package/include sweep_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - function tt_width(N)=1<<N;
  - default golden constant TT_ABBAR_CDBAR=16'h4F44 for reuse by other lab checkers.
- One sub-module, sweep_settle_timer: parametrised SETTLE down-counter with load and expire outputs. Everything else stays in the top FSM.

Test Plan:
- Correct DUT (golden model of a&~b|c&~d), SETTLE=0, pulse start:
  - dut_in steps 0..15, one per cycle;
  - done rises 16 cycles after RUN entry;
  - err_count=0, pass=1, first_fail_valid=0.
- Faulty DUT (y stuck at 0), SETTLE=0:
  - err_count=7 (vectors 2,6,8,9,10,11,14);
  - first_fail_vec=4'd2, first_fail_valid=1, pass=0.
- SETTLE=3 with a DUT whose output is delayed 2 registers:
  - each vector held 4 cycles;
  - done after 64 cycles; err_count=0.
- abort asserted at cycle 5 of RUN (SETTLE=0):
  - IDLE next cycle, busy=0, done=0, err_count holds its partial value.
  - A new start clears the counters and completes a full sweep.
- start and abort asserted together in IDLE: stays in IDLE, busy stays 0. start pulsed mid-RUN: dut_in sequence is unaffected.
- rst pulsed asynchronously mid-sweep, between clock edges:
  - all outputs go to reset values before the next edge;
  - with no start, the block remains in IDLE.
